// File: rtl/backlight_zone_buffer.sv
// backlight_zone_buffer
//
// Collects per-zone white block means in raster order, optionally smooths each
// zone with a first-order IIR, and publishes one backlight frame per video
// frame as an indexed valid/ready stream. Two banks let the stream for frame N
// drain while frame N+1 is being collected.
//
// Optional feature macro: BL_TEMPORAL_FILTER_EN
//   defined   -> IIR filter active, hist array present, first frame bypasses.
//   undefined -> zone value = mean_i, no hist storage.
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   vs                     vertical sync, rising edge = frame boundary
//   mean_i, mean_valid_i   zone mean and its one-cycle qualifier
//   zone_val_o, zone_idx_o published zone value / index (row*H_ZONES+col)
//   out_valid_o, out_ready_i, out_last_o   stream handshake
//   frame_drop_o, underrun_o, overflow_o   per-frame status

module backlight_zone_buffer #(
    parameter int H_ZONES     = 16,
    parameter int V_ZONES     = 9,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       vs,
    input  logic [7:0] mean_i,
    input  logic       mean_valid_i,
    output logic [7:0] zone_val_o,
    output logic [7:0] zone_idx_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o,
    output logic       frame_drop_o,
    output logic       underrun_o,
    output logic       overflow_o
);

    localparam int ZONES = H_ZONES * V_ZONES;
    localparam int IW    = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int CW    = $clog2(ZONES + 1);
    localparam logic [CW-1:0] ZONES_C  = CW'(ZONES);
    localparam logic [IW-1:0] LAST_IDX = IW'(ZONES - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    // Two frame banks; bank_sel is the write bank, ~bank_sel the read bank.
    logic [7:0]    bank [2][ZONES];
    logic          bank_sel;

    logic          vs_d;
    logic          vs_rise;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] wr_cnt_nxt;
    logic          ovf_pend;
    logic          ovf_nxt;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [7:0]    new_val;
    logic [7:0]    head_val;

    state_t        state;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] rd_nxt;

    assign vs_rise = vs && !vs_d;
    assign wr_en   = mean_valid_i && (wr_cnt < ZONES_C);
    assign wr_idx  = wr_cnt[IW-1:0];

    // Count and overflow state including a strobe in this cycle, so a strobe
    // coincident with the boundary is charged to the outgoing frame.
    assign wr_cnt_nxt = wr_en ? wr_cnt + CW'(1) : wr_cnt;
    assign ovf_nxt    = ovf_pend || (mean_valid_i && (wr_cnt == ZONES_C));

`ifdef BL_TEMPORAL_FILTER_EN
    logic [7:0]        hist [ZONES];
    logic              first_frame;
    logic signed [8:0] diff;
    logic [7:0]        step;

    // new = hist + floor((mean - hist) / 2^K); always lands between hist and
    // mean, so the 8-bit add cannot wrap.
    always_comb begin
        diff    = $signed({1'b0, mean_i}) - $signed({1'b0, hist[wr_idx]});
        step    = 8'(diff >>> ALPHA_SHIFT);
        new_val = first_frame ? mean_i : hist[wr_idx] + step;
    end
`else
    assign new_val = mean_i;
`endif

    // Zone 0 of the outgoing bank may be written in the very cycle of the
    // swap; forward it so the first registered beat carries the new value.
    assign head_val = (wr_en && (wr_idx == '0)) ? new_val : bank[bank_sel][0];
    assign rd_nxt   = rd_idx + IW'(1);

    assign zone_idx_o = 8'(rd_idx);

    // Write path: bank/hist storage and frame fill counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++)
                for (int z = 0; z < ZONES; z++)
                    bank[b][z] <= '0;
`ifdef BL_TEMPORAL_FILTER_EN
            for (int z = 0; z < ZONES; z++)
                hist[z] <= '0;
`endif
            wr_cnt   <= '0;
            ovf_pend <= 1'b0;
        end else begin
            if (wr_en) begin
                bank[bank_sel][wr_idx] <= new_val;
`ifdef BL_TEMPORAL_FILTER_EN
                hist[wr_idx] <= new_val;
`endif
            end
            // Cleared on every boundary, including a dropped one, so the next
            // frame overwrites the unpublished bank.
            wr_cnt   <= vs_rise ? '0 : wr_cnt_nxt;
            ovf_pend <= vs_rise ? 1'b0 : ovf_nxt;
        end
    end

    // Readout FSM, bank swap and per-frame status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            vs_d         <= 1'b0;
            bank_sel     <= 1'b0;
            rd_idx       <= '0;
            zone_val_o   <= '0;
            out_valid_o  <= 1'b0;
            out_last_o   <= 1'b0;
            frame_drop_o <= 1'b0;
            underrun_o   <= 1'b0;
            overflow_o   <= 1'b0;
`ifdef BL_TEMPORAL_FILTER_EN
            first_frame  <= 1'b1;
`endif
        end else begin
            vs_d <= vs;
            case (state)
                S_IDLE: begin
                    if (vs_rise) begin
                        bank_sel     <= ~bank_sel;
                        underrun_o   <= (wr_cnt_nxt < ZONES_C);
                        overflow_o   <= ovf_nxt;
                        frame_drop_o <= 1'b0;
`ifdef BL_TEMPORAL_FILTER_EN
                        first_frame  <= 1'b0;
`endif
                        state        <= S_STREAM;
                        rd_idx       <= '0;
                        zone_val_o   <= head_val;
                        out_valid_o  <= 1'b1;
                        out_last_o   <= (ZONES == 1);
                    end
                end
                S_STREAM: begin
                    // A boundary during readout (even on the last beat) is a
                    // drop; the status of the published frame is kept.
                    if (vs_rise)
                        frame_drop_o <= 1'b1;
                    if (out_ready_i) begin
                        if (rd_idx == LAST_IDX) begin
                            state       <= S_IDLE;
                            rd_idx      <= '0;
                            out_valid_o <= 1'b0;
                            out_last_o  <= 1'b0;
                        end else begin
                            rd_idx     <= rd_nxt;
                            zone_val_o <= bank[~bank_sel][rd_nxt];
                            out_last_o <= (rd_nxt == LAST_IDX);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_backlight_zone_buffer.sv
// Directed bench for backlight_zone_buffer at default geometry (16x9, K=2).
// Expected stream contents come from a small bank/hist model kept by the bench;
// filter results are additionally checked against hand-computed constants when
// BL_TEMPORAL_FILTER_EN is defined.

module tb_backlight_zone_buffer;

    localparam int Z = 144;
    localparam int K = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       vs;
    logic [7:0] mean_i;
    logic       mean_valid_i;
    logic [7:0] zone_val_o;
    logic [7:0] zone_idx_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       out_last_o;
    logic       frame_drop_o;
    logic       underrun_o;
    logic       overflow_o;

    backlight_zone_buffer #(.H_ZONES(16), .V_ZONES(9), .ALPHA_SHIFT(K)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .vs           (vs),
        .mean_i       (mean_i),
        .mean_valid_i (mean_valid_i),
        .zone_val_o   (zone_val_o),
        .zone_idx_o   (zone_idx_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_last_o   (out_last_o),
        .frame_drop_o (frame_drop_o),
        .underrun_o   (underrun_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int bank_m [2][Z];
    int hist_m [Z];
    int pub    [Z];
    int cap    [Z];
    bit first_m;
    bit sel_m;
    int wcnt_m;
    bit ovf_m;
    bit exp_under, exp_ovf, exp_drop;

`ifdef BL_TEMPORAL_FILTER_EN
    function automatic int filt(input int h, input int m);
        int d = m - h;
        int q;
        if (d >= 0) q = d / (1 << K);
        else        q = -((-d + (1 << K) - 1) / (1 << K));
        return h + q;
    endfunction
`endif

    task automatic model_reset();
        for (int z = 0; z < Z; z++) begin
            bank_m[0][z] = 0; bank_m[1][z] = 0; hist_m[z] = 0;
        end
        first_m = 1; sel_m = 0; wcnt_m = 0; ovf_m = 0;
        exp_under = 0; exp_ovf = 0; exp_drop = 0;
    endtask

    task automatic model_strobe(input int m);
        int v;
        if (wcnt_m < Z) begin
`ifdef BL_TEMPORAL_FILTER_EN
            v = first_m ? m : filt(hist_m[wcnt_m], m);
`else
            v = m;
`endif
            bank_m[sel_m][wcnt_m] = v;
            hist_m[wcnt_m] = v;
            wcnt_m++;
        end else begin
            ovf_m = 1;
        end
    endtask

    task automatic model_boundary(input bit busy);
        if (busy) begin
            exp_drop = 1;
        end else begin
            pub       = bank_m[sel_m];
            exp_under = (wcnt_m < Z);
            exp_ovf   = ovf_m;
            exp_drop  = 0;
            sel_m     = !sel_m;
            first_m   = 0;
        end
        wcnt_m = 0;
        ovf_m  = 0;
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int m);
        mean_valid_i = 1'b1;
        mean_i       = 8'(m & 255);
        model_strobe(m & 255);
        tick();
        mean_valid_i = 1'b0;
    endtask

    task automatic frame(input int n, input int base, input int step);
        for (int z = 0; z < n; z++) strobe(base + step * z);
    endtask

    task automatic vs_edge(input string tag, input bit busy, input bit with_strobe, input int m);
        vs = 1'b1;
        if (with_strobe) begin
            mean_valid_i = 1'b1;
            mean_i       = 8'(m);
            model_strobe(m);
        end
        model_boundary(busy);
        tick();
        vs = 1'b0;
        mean_valid_i = 1'b0;
        chk({tag, "_valid"}, out_valid_o, 1);
        chk({tag, "_idx0"},  zone_idx_o, 0);
        chk({tag, "_val0"},  zone_val_o, pub[0]);
        chk({tag, "_under"}, underrun_o, exp_under);
        chk({tag, "_ovf"},   overflow_o, exp_ovf);
        chk({tag, "_drop"},  frame_drop_o, exp_drop);
    endtask

    task automatic drain(input string tag, input bit rnd);
        int k = 0;
        int guard = 0;
        while (k < Z && guard < 3000) begin
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!out_valid_o) begin
                chk({tag, "_valid"}, out_valid_o, 1);
                break;
            end
            if (out_ready_i) begin
                chk({tag, "_idx"},  zone_idx_o, k);
                chk({tag, "_val"},  zone_val_o, pub[k]);
                chk({tag, "_last"}, out_last_o, (k == Z - 1));
                cap[k] = int'(zone_val_o);
                k++;
            end
            tick();
            guard++;
        end
        out_ready_i = 1'b0;
        chk({tag, "_beats"}, k, Z);
        chk({tag, "_idle"},  out_valid_o, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; vs = 1'b0; mean_i = '0; mean_valid_i = 1'b0; out_ready_i = 1'b0;
        model_reset();
        tick(); tick();
        chk("rst_valid", out_valid_o, 0);
        chk("rst_idx",   zone_idx_o, 0);
        chk("rst_val",   zone_val_o, 0);
        chk("rst_last",  out_last_o, 0);
        chk("rst_drop",  frame_drop_o, 0);
        chk("rst_under", underrun_o, 0);
        chk("rst_ovf",   overflow_o, 0);
        rstn = 1'b1;
        tick();

        // Full frame, mean = zone index.
        frame(Z, 0, 1);
        vs_edge("full", 0, 0, 0);
        drain("full", 0);
`ifndef BL_TEMPORAL_FILTER_EN
        chk("full_hand0",   cap[0], 0);
        chk("full_hand143", cap[143], 143);
`endif

        // Fill the other bank too, then a short frame: tail keeps old values.
        frame(Z, 0, 1);
        vs_edge("full2", 0, 0, 0);
        drain("full2", 1);
        frame(140, 100, 1);
        vs_edge("under", 0, 0, 0);
        chk("under_flag", underrun_o, 1);
        drain("under", 0);
`ifndef BL_TEMPORAL_FILTER_EN
        chk("under_z139", cap[139], 239);
        chk("under_z140", cap[140], 140);
`endif

        // Overflow: 150 strobes, extras dropped.
        frame(150, 7, 3);
        vs_edge("ovf", 0, 0, 0);
        chk("ovf_flag", overflow_o, 1);
        drain("ovf", 1);
        frame(Z, 3, 1);
        vs_edge("ovf_clr", 0, 0, 0);
        drain("ovf_clr", 1);

        // Stream stalled across a boundary: frame dropped, old bank kept.
        frame(Z, 50, 1);
        vs_edge("pubA", 0, 0, 0);
        frame(Z, 200, 2);
        vs_edge("drop", 1, 0, 0);
        chk("drop_flag", frame_drop_o, 1);
        drain("drop_old", 0);
        frame(Z, 9, 5);
        vs_edge("pubC", 0, 0, 0);
        drain("pubC", 0);

        // Strobe coincident with the boundary belongs to the outgoing frame.
        frame(10, 30, 1);
        vs_edge("coin", 0, 1, 99);
        chk("coin_under", underrun_o, 1);
        drain("coin", 1);
`ifndef BL_TEMPORAL_FILTER_EN
        chk("coin_z10", cap[10], 99);
`endif
        frame(Z, 5, 1);
        vs_edge("coin_next", 0, 0, 0);
        drain("coin_next", 0);

        // Reset mid-stream abandons the stream immediately.
        frame(Z, 11, 1);
        vs_edge("mid", 0, 0, 0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_ready_i = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst_valid", out_valid_o, 0);
        chk("midrst_idx",   zone_idx_o, 0);
        model_reset();
        tick();
        rstn = 1'b1;
        tick();
        // Post-reset first frame: only a zone-0 strobe coincident with vs.
        vs_edge("first", 0, 1, 77);
        chk("first_z0", zone_val_o, 77);
        drain("first", 0);

`ifdef BL_TEMPORAL_FILTER_EN
        do_reset();
        frame(Z, 200, 0);
        vs_edge("f1", 0, 0, 0);
        drain("f1", 0);
        chk("filt_f1", cap[0], 200);
        frame(Z, 0, 0);
        vs_edge("f2", 0, 0, 0);
        drain("f2", 0);
        chk("filt_f2", cap[0], 150);
        frame(Z, 0, 0);
        vs_edge("f3", 0, 0, 0);
        drain("f3", 0);
        chk("filt_f3", cap[0], 112);
        do_reset();
        frame(Z, 9, 0);
        vs_edge("f9", 0, 0, 0);
        drain("f9", 0);
        frame(Z, 10, 0);
        vs_edge("f10", 0, 0, 0);
        drain("f10", 0);
        chk("filt_stick", cap[0], 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/backlight_zone_buffer.md
# backlight_zone_buffer

Collects the per-zone white block means produced by the block-mean/gamma stage, optionally smooths each zone over time, and publishes one complete backlight frame per video frame as an indexed stream toward the LED driver interface. It sits directly downstream of the white block-mean stage and upstream of the backlight driver. It holds two frame banks, so the stream for frame N can drain while frame N+1 is being collected.

## Interface
- H_ZONES, 16: zones per row.
- V_ZONES, 9: zone rows; H_ZONES*V_ZONES ≤ 256.
- ALPHA_SHIFT, 2: temporal filter shift K (1..7).
- clk  in  1  pixel clock; the only clock.
- rstn  in  1  reset, asynchronous, active-low.
- vs  in  1  vertical sync from the video timing, active-high; its rising edge marks the frame boundary.
- mean_i  in  8  gamma-corrected white block mean.
- mean_valid_i  in  1  one-cycle strobe qualifying mean_i; zones arrive in raster order.
- zone_val_o  out  8  published zone value.
- zone_idx_o  out  8  zone index, row*H_ZONES+col.
- out_valid_o  out  1  stream valid.
- out_ready_i  in  1  stream ready from the driver.
- out_last_o  out  1  high with the final zone (index ZONES-1).
- frame_drop_o  out  1  per-frame status: a swap was skipped because the readout was busy.
- underrun_o  out  1  per-frame status: fewer than ZONES means arrived.
- overflow_o  out  1  per-frame status: more than ZONES means arrived; the extras were discarded.

## Operation
- ZONES = H_ZONES*V_ZONES. Storage is register arrays:
  - wbank: write bank.
  - rbank: read bank.
  - hist: filter state, 8 bits each.
- Write path:
  - wr_cnt counts accepted strobes from 0.
  - On mean_valid_i with wr_cnt<ZONES, the filtered value goes to wbank[wr_cnt] and hist[wr_cnt], then wr_cnt increments.
  - At wr_cnt==ZONES, strobes are discarded and ovf_pend is set.
  - wr_cnt saturates at ZONES.
- Filter arithmetic:
  - d = {1'b0,mean_i} − {1'b0,hist[z]}, a 9-bit signed value.
  - s = d >>> ALPHA_SHIFT (arithmetic shift, floor).
  - new = hist[z] + s, truncated to 8 bits.
  - The result always lies between hist and mean, so the add never overflows.
  - Upward convergence stops within 2^K−1 codes of the target; this is intended.
- First frame after reset: first_frame=1 bypasses the filter (new = mean_i). first_frame clears at the first swap.
- Frame boundary: a vs rising edge, detected with a registered vs_d.
  - Readout idle: swap wbank/rbank roles (bank-select toggle). Then:
    - underrun_o = (wr_cnt<ZONES).
    - overflow_o = ovf_pend.
    - frame_drop_o = 0.
    - wr_cnt = 0 and ovf_pend = 0.
    - The readout starts.
  - Readout busy: no swap; frame_drop_o = 1 and underrun_o/overflow_o are unchanged.
    - wr_cnt and ovf_pend are still cleared, so the next frame overwrites the unpublished bank.
- Underrun zones are not written, so the bank keeps its older contents for them. No zeroing is done.
- Readout FSM:
  - IDLE → STREAM on swap, with rd_idx=0.
  - In STREAM, out_valid_o=1, zone_idx_o=rd_idx and zone_val_o=rbank[rd_idx] (registered).
  - On valid&&ready: rd_idx increments. If rd_idx==ZONES−1, go to IDLE.
  - out_last_o = STREAM && rd_idx==ZONES−1.
  - The outputs are held stable while valid&&!ready.

## Timing
- Reset values:
  - All outputs 0.
  - wr_cnt=0, rd_idx=0, FSM=IDLE, first_frame=1, bank select=0.
  - hist and both banks are cleared to 0.
- Write latency: mean_valid_i at cycle t → array updated at t+1. Back-to-back strobes (every cycle) are supported.
- A strobe in the same cycle as the vs rising-edge detection belongs to the outgoing frame. It is written to the outgoing bank before the swap and counted in that frame's underrun/overflow status.
- vs rise seen at cycle n (vs=1, vs_d=0) → bank swap and status update at n+1 → out_valid_o=1 with index 0 from n+1.
- Stream throughput is one zone per cycle when ready is held high, so a full frame drains in ZONES cycles.
- Readout ending (last handshake) in the same cycle as a vs rise counts as busy, so that frame is dropped.
- An asynchronous reset mid-frame or mid-stream immediately returns to the reset state. Any partial stream is abandoned with out_valid_o=0.

## Configuration
- BL_TEMPORAL_FILTER_EN defined: the IIR filter is active as described, and the hist array is instantiated.
- BL_TEMPORAL_FILTER_EN undefined:
  - new = mean_i always, and hist is removed.
  - first_frame is unused.
  - Everything else is identical, including the one-cycle write latency.

## Test plan
- Defaults, filter off: 144 strobes with mean=zone index; vs rise; ready=1 → 144 beats, idx 0..143, val=idx, last only on 143, underrun/overflow/drop=0.
- Filter on, K=2, one zone:
  - Frame 1 mean=200 → 200.
  - Frame 2 mean=0 → 150.
  - Frame 3 mean=0 → 112.
  - A hist=9, mean=10 case stays at 9.
- 140 strobes then vs → underrun_o=1, and zones 140..143 stream their previous-frame values. 150 strobes → overflow_o=1, and zones 0..143 are correct.
- out_ready_i held low across the next vs rise → frame_drop_o=1 and the stream keeps the old bank. After release, the next vs publishes the newest frame.
- Strobe coincident with the vs rise → written as zone wr_cnt of the outgoing frame; the new frame starts at index 0. Random ready backpressure → no beats lost or duplicated.
- rstn pulsed low mid-stream → out_valid_o=0 immediately. A post-reset first frame bypasses the filter.
